// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: round-robin sharing of the pmem line port between the I-cache and D-cache
module cacheline_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;
    state_t state, state_nxt;
    logic   last_d, last_d_nxt;
    logic   d_req;
    assign d_req   = d_read | d_write;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state  <= state_nxt;
            last_d <= last_d_nxt;
        end
    // a dropped request while granted abandons the grant; a response always wins
    always_comb begin
        state_nxt  = state;
        last_d_nxt = last_d;
        pmem_addr  = '0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_wdata = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state)
            IDLE: state_nxt = (i_read & d_req) ? (last_d ? SERVE_I : SERVE_D) :
                              i_read ? SERVE_I : d_req ? SERVE_D : IDLE;
            SERVE_I: begin
                pmem_addr = i_addr;
                pmem_read = 1'b1;
                i_resp    = pmem_resp;
                if (pmem_resp) begin
                    state_nxt  = RELEASE;
                    last_d_nxt = 1'b0;
                end else if (!i_read)
                    state_nxt = IDLE;
            end
            SERVE_D: begin
                pmem_addr  = d_addr;
                pmem_read  = d_read & ~d_write;
                pmem_write = d_write;
                pmem_wdata = d_wdata;
                d_resp     = pmem_resp;
                if (pmem_resp) begin
                    state_nxt  = RELEASE;
                    last_d_nxt = 1'b1;
                end else if (!d_req)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: scoreboard bench with a line-memory model and a round-robin grant model
`timescale 1ns/1ps
module tb_cacheline_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;
    localparam logic [LW-1:0] PAT_B = {8{32'hB0B0_1234}};
    localparam logic [LW-1:0] PAT_C = {8{32'hCAFE_F00D}};
    localparam logic [LW-1:0] PAT_E = {8{32'hE1E1_5A5A}};
    typedef struct {
        logic [AW-1:0] addr;
        logic          rd;
        logic          wr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
    } req_t;
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [AW-1:0] d_addr = '0;
    logic          i_read = 1'b0;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] i_rdata, d_rdata, pmem_wdata, pmem_rdata;
    logic          i_resp, d_resp, pmem_read, pmem_write, pmem_resp;
    logic [AW-1:0] pmem_addr;
    req_t          iq[$];
    req_t          dq[$];
    logic [AW-1:0] txn_log[$];
    logic [LW-1:0] mem[logic [AW-1:0]];
    logic [LW-1:0] ref_mem[logic [AW-1:0]];
    int            checks = 0;
    int            errors = 0;
    int            fixed_lat = -1;
    int            stray_cnt = 0;

    cacheline_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_addr(pmem_addr), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
        return {8{a ^ 32'hC0DE_0000}};
    endfunction

    function automatic logic [LW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem.exists(a) ? mem[a] : init_line(a);
    endfunction

    function automatic void chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endfunction

    function automatic logic [AW-1:0] log_at(input int idx);
        return idx < txn_log.size() ? txn_log[idx] : 'x;
    endfunction

    // line memory: answers each request after a fixed or random delay
    initial begin
        int  cnt = 0;
        int  lat = 0;
        int  seen = 0;
        bit  was;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            was        = pmem_resp;
            pmem_resp  = 1'b0;
            pmem_rdata = {8{$urandom}};
            if (!rst)
                cnt = 0;
            else if (stray_cnt != seen) begin
                seen      = stray_cnt;
                pmem_resp = 1'b1;
            end else if (!was && (pmem_read || pmem_write)) begin
                if (cnt == 0)
                    lat = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 4));
                if (cnt >= lat) begin
                    pmem_resp = 1'b1;
                    if (pmem_write)
                        mem[pmem_addr] = pmem_wdata;
                    else
                        pmem_rdata = mem_rd(pmem_addr);
                    cnt = 0;
                end else
                    cnt++;
            end
        end
    end

    // monitor: grant model (pending set + round robin) and response scoreboard
    initial begin
        bit   prev_act = 0, prev_i = 0, prev_d = 0, last_d = 0, rel = 0;
        bit   act, side, ei, ed;
        int   gnt = 0;
        req_t r;
        forever begin
            @(negedge clk);
            act = pmem_read | pmem_write;
            if (!rst) begin
                gnt = 0; last_d = 0; rel = 0;
                prev_act = 0; prev_i = 0; prev_d = 0;
                iq.delete();
                dq.delete();
                continue;
            end
            if (rel)
                chk("release_idle", act, 0);
            rel = 0;
            if (act && !prev_act) begin
                side = (prev_i && prev_d) ? !last_d : prev_d;
                txn_log.push_back(pmem_addr);
                if (side ? dq.size() == 0 : iq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_side: pmem request at %0h, required no request", pmem_addr);
                end else begin
                    if (side) r = dq[0];
                    else r = iq[0];
                    chk("grant_addr", pmem_addr, r.addr);
                    chk("grant_write", pmem_write, r.wr);
                    chk("grant_read", pmem_read, r.rd & ~r.wr);
                    if (r.wr)
                        chk("grant_wdata", pmem_wdata, r.wdata);
                    gnt = side ? 2 : 1;
                end
            end else if (act && gnt == 0)
                chk("unexpected_pmem_req", act, 0);
            if (gnt == 1)
                chk("proto_i_hold", i_read, 1);
            if (gnt == 2)
                chk("proto_d_hold", d_read | d_write, 1);
            ei = gnt == 1 && pmem_resp;
            ed = gnt == 2 && pmem_resp;
            if (ei || i_resp)
                chk("i_resp", i_resp, ei);
            if (ed || d_resp)
                chk("d_resp", d_resp, ed);
            if (ei) begin
                r = iq.pop_front();
                chk("i_rdata", i_rdata, r.rdata);
                last_d = 0; gnt = 0; rel = 1;
            end
            if (ed) begin
                r = dq.pop_front();
                if (!r.wr)
                    chk("d_rdata", d_rdata, r.rdata);
                last_d = 1; gnt = 0; rel = 1;
            end
            prev_act = act;
            prev_i   = i_read;
            prev_d   = d_read | d_write;
        end
    end

    task automatic start_i(input logic [AW-1:0] a);
        req_t r;
        r.addr = a; r.rd = 1'b1; r.wr = 1'b0; r.wdata = '0; r.rdata = init_line(a);
        iq.push_back(r);
        i_addr = a;
        i_read = 1'b1;
    endtask

    task automatic start_d(input logic [AW-1:0] a, input logic rd, input logic wr, input logic [LW-1:0] wd);
        req_t r;
        r.addr = a; r.rd = rd; r.wr = wr; r.wdata = wd;
        r.rdata = ref_mem.exists(a) ? ref_mem[a] : init_line(a);
        if (wr)
            ref_mem[a] = wd;
        dq.push_back(r);
        d_addr  = a;
        d_read  = rd;
        d_write = wr;
        d_wdata = wd;
    endtask

    task automatic finish(input bit d, input bit drop);
        int n = 0;
        while ((d ? dq.size() : iq.size()) != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_done: still pending after %0d cycles, required a response", d ? "d" : "i", n);
        end
        #1;
        if (drop) begin
            if (d) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end else
                i_read = 1'b0;
        end
    endtask

    task automatic i_agent(input int n);
        int g;
        for (int k = 0; k < n; k++) begin
            g = $urandom_range(0, 3);
            start_i({16'h0001, 11'($urandom), 5'b0});
            finish(0, g != 0);
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end
        i_read = 1'b0;
    endtask

    task automatic d_agent(input int n);
        int g, op;
        for (int k = 0; k < n; k++) begin
            g  = $urandom_range(0, 3);
            op = $urandom_range(0, 4);
            start_d({1'b1, 22'b0, 4'($urandom), 5'b0}, op >= 2, op < 2 || op == 4, {8{$urandom}});
            finish(1, g != 0);
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end
        d_read  = 1'b0;
        d_write = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, n;
        repeat (2) @(negedge clk);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_addr", pmem_addr, 0);
        chk("rst_resps", {i_resp, d_resp}, 0);
        @(posedge clk);
        #1 rst = 1'b1;

        fixed_lat = 5;
        @(posedge clk);
        #1 start_i(32'h0000_1000);
        @(negedge clk);
        chk("i_idle_no_req", pmem_read, 0);
        @(negedge clk);
        chk("i_pmem_read", pmem_read, 1);
        chk("i_pmem_addr", pmem_addr, 32'h0000_1000);
        finish(0, 1);
        @(negedge clk);
        chk("i_resp_single", i_resp, 0);
        chk("i_d_resp_quiet", d_resp, 0);

        fixed_lat = 3;
        @(posedge clk);
        #1 start_d(32'h0000_2040, 1'b0, 1'b1, PAT_B);
        @(negedge clk);
        chk("d_idle_no_req", pmem_write, 0);
        @(negedge clk);
        chk("d_pmem_write", pmem_write, 1);
        chk("d_pmem_read", pmem_read, 0);
        chk("d_pmem_wdata", pmem_wdata, PAT_B);
        finish(1, 1);
        @(negedge clk);
        chk("d_release_no_req", pmem_read | pmem_write, 0);
        chk("d_resp_single", d_resp, 0);
        @(posedge clk);
        #1 start_d(32'h0000_2040, 1'b1, 1'b0, '0);
        finish(1, 1);

        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        fixed_lat = 2;
        base = txn_log.size();
        start_d(32'h0000_2080, 1'b1, 1'b0, '0);
        start_i(32'h0000_1100);
        fork
            finish(1, 1);
            finish(0, 1);
        join
        chk("both_first_d", log_at(base), 32'h0000_2080);
        chk("both_then_i", log_at(base + 1), 32'h0000_1100);

        fixed_lat = 1;
        base = txn_log.size();
        fork
            begin
                start_d(32'h0000_2040, 1'b1, 1'b0, '0);
                finish(1, 0);
                start_d(32'h0000_20C0, 1'b0, 1'b1, PAT_E);
                finish(1, 1);
            end
            begin
                start_i(32'h0000_1140);
                finish(0, 0);
                start_i(32'h0000_1180);
                finish(0, 1);
            end
        join
        chk("rr_0_d", log_at(base), 32'h0000_2040);
        chk("rr_1_i", log_at(base + 1), 32'h0000_1140);
        chk("rr_2_d", log_at(base + 2), 32'h0000_20C0);
        chk("rr_3_i", log_at(base + 3), 32'h0000_1180);

        @(posedge clk);
        #1 start_d(32'h0000_20C0, 1'b1, 1'b0, '0);
        finish(1, 1);
        fixed_lat = 10;
        @(posedge clk);
        #1 start_d(32'h0000_3000, 1'b0, 1'b1, PAT_C);
        n = 0;
        while (!pmem_write && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("mid_granted", pmem_write, 1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("mid_async_write", pmem_write, 0);
        chk("mid_async_addr", pmem_addr, 0);
        chk("mid_no_d_resp", d_resp, 0);
        d_write = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_hold_d_resp", d_resp, 0);
            chk("mid_hold_write", pmem_write, 0);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        fixed_lat = 2;
        base = txn_log.size();
        start_d(32'h0000_2040, 1'b1, 1'b0, '0);
        start_i(32'h0000_1200);
        fork
            finish(1, 1);
            finish(0, 1);
        join
        chk("post_rst_first_d", log_at(base), 32'h0000_2040);
        chk("post_rst_then_i", log_at(base + 1), 32'h0000_1200);

        @(posedge clk);
        #1 stray_cnt++;
        @(negedge clk);
        chk("stray_i_resp", i_resp, 0);
        chk("stray_d_resp", d_resp, 0);
        @(negedge clk);
        chk("stray_no_req", pmem_read | pmem_write, 0);
        @(posedge clk);
        #1 start_i(32'h0000_1240);
        finish(0, 1);

        fixed_lat = -1;
        fork
            i_agent(40);
            d_agent(40);
        join
        repeat (5) @(posedge clk);
        chk("queues_drained", iq.size() + dq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
